msrv32_pipe_skid_reg: RTL
=========================

MSRV32_PIPE_SKID_REG -- requirements
Module: msrv32_pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of the datapath payload (operands, PC, immediate).
REQ-002 The block SHALL have parameter CTRL_W, default 16: width of the control payload (write enables, mux selects, opcodes), forced to zero on bubbles.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port flush_in, input, 1 bit: synchronous kill of all held entries.
REQ-006 The block SHALL have port in_valid_in, input, 1 bit: the upstream stage offers a payload.
REQ-007 The block SHALL have port in_ready_out, output, 1 bit: the block can accept a payload this cycle.
REQ-008 The block SHALL have port in_data_in, input, DATA_W bits: the upstream datapath payload.
REQ-009 The block SHALL have port in_ctrl_in, input, CTRL_W bits: the upstream control payload.
REQ-010 The block SHALL have port out_valid_out, output, 1 bit: the block presents a payload downstream.
REQ-011 The block SHALL have port out_ready_in, input, 1 bit: the downstream stage takes the payload.
REQ-012 The block SHALL have port out_data_out, output, DATA_W bits: the presented datapath payload.
REQ-013 The block SHALL have port out_ctrl_out, output, CTRL_W bits: the presented control payload.
REQ-014 The block SHALL have port occupancy_out, output, 2 bits: the number of held entries, 0 to 2.
REQ-015 The block SHALL have port stall_cnt_out, output, 32 bits, present only under MSRV32_PIPE_STALL_CNT_EN: the downstream-stall cycle count.

Function
REQ-016 The block SHALL hold two entries: main (drives the outputs) and skid; each entry holds data, ctrl and a valid bit.
REQ-017 The block SHALL have states EMPTY (occupancy 0), ONE (main valid) and FULL (main and skid valid).
REQ-018 The block SHALL define accept = in_valid_in & in_ready_out and take = out_valid_out & out_ready_in.
REQ-019 in_ready_out SHALL equal 1 exactly when the state is not FULL, and SHALL be a registered signal with no combinational path from out_ready_in.
REQ-020 out_valid_out SHALL equal the main valid bit, a registered signal.
REQ-021 In EMPTY, an accept SHALL load main from the inputs and move to ONE; with no accept the state SHALL stay EMPTY.
REQ-022 In ONE, accept with take SHALL load main from the inputs and stay ONE.
REQ-023 In ONE, accept without take SHALL load skid from the inputs and move to FULL.
REQ-024 In ONE, take without accept SHALL move to EMPTY; with neither, the state SHALL hold.
REQ-025 In FULL, take SHALL copy skid into main and move to ONE; without take the state SHALL hold; no accept is possible in FULL.
REQ-026 Latency SHALL be 1 cycle from accept to out_valid_out, and sustained throughput SHALL be 1 payload per cycle while out_ready_in=1.
REQ-027 Ordering SHALL be strict FIFO, with no payload lost or duplicated.
REQ-028 out_ctrl_out SHALL equal main ctrl when out_valid_out=1 and SHALL be all-zero otherwise, so bubbles carry no write enables.
REQ-029 When out_valid_out=0, out_data_out SHALL hold its last value.
REQ-030 flush_in=1 SHALL take priority over all other events: next state EMPTY, both valid bits cleared, and any same-cycle accept discarded.
REQ-031 Because in_ready_out is registered, it SHALL read 1 in the cycle after a flush.
REQ-032 A take in the flush cycle SHALL still count as delivered downstream.
REQ-033 Data registers SHALL NOT be reset, so that the DATA_W-wide flops need no reset.

Reset
REQ-034 While reset_n_in=0, asynchronously: state EMPTY, both valid bits 0, in_ready_out=0, out_valid_out=0, out_ctrl_out=0, occupancy_out=0, stall_cnt_out=0.
REQ-035 On the first rising clk_in edge after reset_n_in rises, in_ready_out SHALL become 1.
REQ-036 Reset asserted mid-transfer SHALL discard all held entries without emitting any partial payload.

Configuration
REQ-037 With MSRV32_PIPE_STALL_CNT_EN defined, stall_cnt_out SHALL increment by 1 on each cycle with out_valid_out=1 and out_ready_in=0.
REQ-038 With MSRV32_PIPE_STALL_CNT_EN defined, stall_cnt_out SHALL saturate at 0xFFFFFFFF and SHALL be cleared by reset only (flush does not clear it).
REQ-039 With MSRV32_PIPE_STALL_CNT_EN undefined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-040 Bench: reset, then in_valid_in=1 with data 0x11..0x18 on consecutive cycles, out_ready_in=1 -> out_valid_out=1 from cycle 1, outputs 0x11..0x18 in order, in_ready_out stays 1, occupancy_out=1.
REQ-041 Bench: out_ready_in=0, push 0xA, 0xB -> occupancy_out=2, in_ready_out=0; a third offer 0xC is held upstream; release out_ready_in -> output order 0xA, 0xB, 0xC.
REQ-042 Bench: FULL with ctrl 0x00FF, assert flush_in for 1 cycle with in_valid_in=1 -> next cycle occupancy_out=0, out_valid_out=0, out_ctrl_out=0x0000, and the offered payload never appears.
REQ-043 Bench: ONE state, drop reset_n_in mid-cycle -> out_valid_out=0 and in_ready_out=0 immediately (before the next edge); after release, in_ready_out=1 after one edge.
REQ-044 Bench (STALL_CNT_EN): hold out_ready_in=0 for 5 cycles with a valid payload, then flush -> stall_cnt_out=5 and retains 5 after the flush.
REQ-045 Bench: random valid/ready at 50% each for 10000 cycles -> scoreboard shows in-order, lossless delivery, and no cycle with in_ready_out=1 while occupancy_out=2.

Source files
------------

// File: rtl/msrv32_pipe_skid_reg_if.sv
// Handshake bundle around one pipeline skid register: upstream offer/ready and downstream payload/ready.
// The slave modport is the register's view; the master modport is the surrounding pipeline's view.
interface msrv32_pipe_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
);
    logic              in_valid_in;
    logic              in_ready_out;
    logic [DATA_W-1:0] in_data_in;
    logic [CTRL_W-1:0] in_ctrl_in;
    logic              out_valid_out;
    logic              out_ready_in;
    logic [DATA_W-1:0] out_data_out;
    logic [CTRL_W-1:0] out_ctrl_out;

    modport slave (
        input  in_valid_in,
        input  in_data_in,
        input  in_ctrl_in,
        input  out_ready_in,
        output in_ready_out,
        output out_valid_out,
        output out_data_out,
        output out_ctrl_out
    );

    modport master (
        output in_valid_in,
        output in_data_in,
        output in_ctrl_in,
        output out_ready_in,
        input  in_ready_out,
        input  out_valid_out,
        input  out_data_out,
        input  out_ctrl_out
    );
endinterface

// File: rtl/msrv32_pipe_skid_reg.sv
// Two-entry pipeline skid register (main + skid); MSRV32_PIPE_STALL_CNT_EN adds a downstream-stall counter.
// Latency: 1 cycle accept-to-valid, full throughput while downstream is ready.
// Backpressure: in_ready_out is registered (low only when FULL), so no ready path crosses the stage.
module msrv32_pipe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  flush_in,
    msrv32_pipe_skid_reg_if.slave bus,
    output logic [1:0]            occupancy_out
`ifdef MSRV32_PIPE_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt_out
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              main_vld_q, skid_vld_q, in_rdy_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

    logic accept, take;
    logic ld_main_in, ld_main_skid, ld_skid;

    assign accept = bus.in_valid_in & in_rdy_q;
    assign take   = main_vld_q & bus.out_ready_in;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && take) begin
                    ld_main_in = 1'b1;
                end else if (accept) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    state_d      = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins; suppressing the loads also keeps out_data_out frozen on the bubble.
        if (flush_in) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= EMPTY;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_vld_q <= (state_d != EMPTY);
            skid_vld_q <= (state_d == FULL);
            in_rdy_q   <= (state_d != FULL);
        end
    end

    // Payload flops carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk_in) begin
        if (ld_main_in) begin
            main_data_q <= bus.in_data_in;
            main_ctrl_q <= bus.in_ctrl_in;
        end else if (ld_main_skid) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
        end
        if (ld_skid) begin
            skid_data_q <= bus.in_data_in;
            skid_ctrl_q <= bus.in_ctrl_in;
        end
    end

    assign bus.in_ready_out  = in_rdy_q;
    assign bus.out_valid_out = main_vld_q;
    assign bus.out_data_out  = main_data_q;
    assign bus.out_ctrl_out  = main_vld_q ? main_ctrl_q : '0;
    assign occupancy_out     = {skid_vld_q, main_vld_q & ~skid_vld_q};

`ifdef MSRV32_PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Survives flush on purpose: it measures downstream back-pressure over the whole run.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            stall_cnt_q <= '0;
        end else if (main_vld_q && !bus.out_ready_in && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_out = stall_cnt_q;
`endif

endmodule
